// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - IF stage sequencer: PC, next-PC select, IF/ID register
// Optional out-of-range fetch trap enabled by defining FETCH_BOUNDS_CHECK_EN.
module fetch_controller #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BOOT_CYCLES = 2,
    parameter int          IMEM_WORDS  = 1024
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        stallIn,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic        jumpTaken,
    input  logic [31:0] jumpTarget,
    input  logic [31:0] imemInstr,
    output logic [31:0] imemAddr,
    output logic [31:0] ifidInstr,
    output logic [31:0] ifidPCPlus4,
    output logic        ifidValid,
    output logic [31:0] fetchCount,
    output logic        addrFault
);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_FAULT} state_t;

    state_t      state_q;
    logic [3:0]  boot_cnt_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pcp4_q;
    logic        valid_q;
    logic [31:0] count_q;

    logic [31:0] pc_plus4_d;
    logic [31:0] branch_pc_d;
    logic [31:0] jump_pc_d;
    logic        oor_d;

    if (BOOT_CYCLES < 1 || BOOT_CYCLES > 15 || IMEM_WORDS < 1) begin : g_param_check
        $error("fetch_controller: BOOT_CYCLES must be 1..15 and IMEM_WORDS >= 1");
    end

    assign pc_plus4_d  = pc_q + 32'd4;
    assign branch_pc_d = branchTarget & ~32'h3;
    assign jump_pc_d   = jumpTarget & ~32'h3;

`ifdef FETCH_BOUNDS_CHECK_EN
    assign oor_d     = {2'b00, pc_q[31:2]} >= 32'(IMEM_WORDS);
    assign addrFault = (state_q == S_FAULT);
`else
    assign oor_d     = 1'b0;
    assign addrFault = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_BOOT;
            boot_cnt_q <= '0;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            pcp4_q     <= '0;
            valid_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            case (state_q)
                S_BOOT: begin
                    boot_cnt_q <= boot_cnt_q + 4'd1;
                    if (boot_cnt_q == 4'(BOOT_CYCLES - 1)) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Branch outranks jump: it belongs to the older instruction in the pipe.
                    if (branchTaken) begin
                        pc_q    <= branch_pc_d;
                        instr_q <= '0;
                        valid_q <= 1'b0;
                    end else if (jumpTaken) begin
                        pc_q    <= jump_pc_d;
                        instr_q <= '0;
                        valid_q <= 1'b0;
                    end else if (stallIn) begin
                        pc_q <= pc_q;
                    end else if (oor_d) begin
                        state_q <= S_FAULT;
                        instr_q <= '0;
                        valid_q <= 1'b0;
                    end else begin
                        pc_q    <= pc_plus4_d;
                        instr_q <= imemInstr;
                        pcp4_q  <= pc_plus4_d;
                        valid_q <= 1'b1;
                        count_q <= count_q + 32'd1;
                    end
                end
                default: begin
                    // Fault is sticky until Reset.
                    state_q <= S_FAULT;
                end
            endcase
        end
    end

    assign imemAddr    = pc_q;
    assign ifidInstr   = instr_q;
    assign ifidPCPlus4 = pcp4_q;
    assign ifidValid   = valid_q;
    assign fetchCount  = count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed plus random checks of fetch_controller against a reference model
module tb_fetch_controller;

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam int IMEM   = 4;
    localparam bit BOUNDS = 1'b1;
`else
    localparam int IMEM   = 1024;
    localparam bit BOUNDS = 1'b0;
`endif
    localparam int BOOT = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        stallIn = 1'b0;
    logic        branchTaken = 1'b0;
    logic        jumpTaken = 1'b0;
    logic [31:0] branchTarget = '0;
    logic [31:0] jumpTarget = '0;
    logic [31:0] imemInstr;
    logic [31:0] imemAddr;
    logic [31:0] ifidInstr;
    logic [31:0] ifidPCPlus4;
    logic        ifidValid;
    logic [31:0] fetchCount;
    logic        addrFault;

    int total = 0;
    int bad = 0;

    logic [31:0] m_pc, m_instr, m_p4, m_cnt;
    logic        m_valid, m_fault;
    int          m_boot;

    fetch_controller #(
        .RESET_PC   (32'h0000_0000),
        .BOOT_CYCLES(BOOT),
        .IMEM_WORDS (IMEM)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .stallIn     (stallIn),
        .branchTaken (branchTaken),
        .branchTarget(branchTarget),
        .jumpTaken   (jumpTaken),
        .jumpTarget  (jumpTarget),
        .imemInstr   (imemInstr),
        .imemAddr    (imemAddr),
        .ifidInstr   (ifidInstr),
        .ifidPCPlus4 (ifidPCPlus4),
        .ifidValid   (ifidValid),
        .fetchCount  (fetchCount),
        .addrFault   (addrFault)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imemInstr = mem_word(imemAddr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic br, input logic jp,
                        input logic [31:0] bt, input logic [31:0] jt);
        Reset = rst;
        stallIn = st;
        branchTaken = br;
        jumpTaken = jp;
        branchTarget = bt;
        jumpTarget = jt;
        @(posedge Clk);
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_p4 = 32'h0; m_cnt = 32'h0;
            m_valid = 1'b0; m_fault = 1'b0; m_boot = BOOT;
        end else if (m_boot > 0) begin
            m_boot--;
        end else if (m_fault) begin
            m_fault = 1'b1;
        end else if (br) begin
            m_pc = bt - (bt % 4); m_instr = 32'h0; m_valid = 1'b0;
        end else if (jp) begin
            m_pc = jt - (jt % 4); m_instr = 32'h0; m_valid = 1'b0;
        end else if (st) begin
            m_cnt = m_cnt;
        end else if (BOUNDS && (m_pc / 4) >= IMEM) begin
            m_fault = 1'b1; m_instr = 32'h0; m_valid = 1'b0;
        end else begin
            m_instr = mem_word(m_pc);
            m_p4 = m_pc + 32'd4;
            m_pc = m_p4;
            m_valid = 1'b1;
            m_cnt = m_cnt + 32'd1;
        end
        #1;
        check("imemAddr", imemAddr, m_pc);
        check("ifidInstr", ifidInstr, m_instr);
        check("ifidPCPlus4", ifidPCPlus4, m_p4);
        check("ifidValid", {31'b0, ifidValid}, {31'b0, m_valid});
        check("fetchCount", fetchCount, m_cnt);
        check("addrFault", {31'b0, addrFault}, {31'b0, m_fault});
    endtask

    initial begin
        logic [31:0] bt, jt;
        // reset and boot
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("boot_valid_low", {31'b0, ifidValid}, 32'd0);
        // fetch 0,4 then stall at 8 then resume
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        check("stall_hold_pc", imemAddr, 32'h8);
        step(0, 0, 0, 0, 0, 0);
        check("three_fetches", fetchCount, 32'd3);
        // branch during stall, then fetch the target
        step(0, 1, 1, 0, 32'h40, 0);
        step(0, 0, 0, 0, 0, 0);
        // branch beats jump; misaligned jump target
        step(0, 0, 1, 1, 32'h100, 32'h200);
        step(0, 0, 0, 1, 0, 32'h203);
        step(0, 0, 0, 0, 0, 0);
        // PC wraps past the top of the address space
        step(0, 0, 0, 1, 0, 32'hFFFF_FFFE);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // reset during a stall at 0x20
        step(0, 0, 0, 1, 0, 32'h20);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        check("reset_pc", imemAddr, 32'h0);
        step(0, 1, 1, 1, 32'h80, 32'h90);
        step(0, 0, 1, 0, 32'h80, 0);
        // run off the end of memory, redirect and stall attempts, then reset
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 32'h0);
        step(0, 1, 1, 0, 32'h4, 0);
        step(1, 0, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 500; i++) begin
            bt = BOUNDS ? $urandom_range(0, 31) : $urandom();
            jt = BOUNDS ? $urandom_range(0, 31) : $urandom();
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), bt, jt);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
